// File: rtl/ahb_mux_m2s.sv
// Master-to-slave AHB-Lite mux: arbitrates M1/M2/default and steers address/control by owner, write data by data-phase owner.
// Grant registered one HREADY edge after request; ownership one edge after grant; all state frozen while HREADY=0.
module ahb_mux_m2s #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HREADY,
    input  logic                 HBUSREQ_M1,
    input  logic                 HBUSREQ_M2,
    input  logic                 HLOCK_M1,
    input  logic                 HLOCK_M2,
    input  logic [ADDR_BITS-1:0] HADDR_M1,
    input  logic [1:0]           HTRANS_M1,
    input  logic                 HWRITE_M1,
    input  logic [2:0]           HSIZE_M1,
    input  logic [2:0]           HBURST_M1,
    input  logic [DATA_BITS-1:0] HWDATA_M1,
    input  logic [ADDR_BITS-1:0] HADDR_M2,
    input  logic [1:0]           HTRANS_M2,
    input  logic                 HWRITE_M2,
    input  logic [2:0]           HSIZE_M2,
    input  logic [2:0]           HBURST_M2,
    input  logic [DATA_BITS-1:0] HWDATA_M2,
    output logic                 HGRANT_M1,
    output logic                 HGRANT_M2,
    output logic [1:0]           HMASTER,
    output logic                 HMASTLOCK,
    output logic [ADDR_BITS-1:0] HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [DATA_BITS-1:0] HWDATA
);

    localparam logic [1:0] MST_DEF      = 2'd0;
    localparam logic [1:0] MST_M1       = 2'd1;
    localparam logic [1:0] MST_M2       = 2'd2;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    logic [1:0] gnt;
    logic [1:0] gnt_next;
    logic [1:0] dmaster;
    logic [1:0] last_served;
    logic [4:0] cnt;
    logic [4:0] cnt_next;
    logic       gnt_lock;
    logic       hold;

    // Beats remaining after a NONSEQ; undefined-length INCR counts as a single beat.
    function automatic logic [4:0] burst_last(input logic [2:0] burst);
        case (burst[2:1])
            2'b01:   return 5'd3;
            2'b10:   return 5'd7;
            2'b11:   return 5'd15;
            default: return 5'd0;
        endcase
    endfunction

    always_comb begin
        HADDR  = '0;
        HTRANS = TRANS_IDLE;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
        HBURST = 3'b000;
        case (HMASTER)
            MST_M1: begin
                HADDR  = HADDR_M1;
                HTRANS = HTRANS_M1;
                HWRITE = HWRITE_M1;
                HSIZE  = HSIZE_M1;
                HBURST = HBURST_M1;
            end
            MST_M2: begin
                HADDR  = HADDR_M2;
                HTRANS = HTRANS_M2;
                HWRITE = HWRITE_M2;
                HSIZE  = HSIZE_M2;
                HBURST = HBURST_M2;
            end
            default: ;
        endcase
    end

    always_comb begin
        HWDATA = '0;
        case (dmaster)
            MST_M1:  HWDATA = HWDATA_M1;
            MST_M2:  HWDATA = HWDATA_M2;
            default: ;
        endcase
    end

    always_comb begin
        cnt_next = cnt;
        if (HTRANS == TRANS_NONSEQ) begin
            cnt_next = burst_last(HBURST);
        end else if (HTRANS == TRANS_SEQ && cnt != 5'd0) begin
            cnt_next = cnt - 5'd1;
        end
    end

    assign gnt_lock = (gnt == MST_M1 && HLOCK_M1) || (gnt == MST_M2 && HLOCK_M2);
    // Release the grant one beat early so the next owner's address phase overlaps the last data beat.
    assign hold     = gnt_lock || (cnt_next >= 5'd2);

    always_comb begin
        gnt_next = gnt;
        if (!hold) begin
            if (HBUSREQ_M1 && HBUSREQ_M2) begin
                gnt_next = (last_served == MST_M1) ? MST_M2 : MST_M1;
            end else if (HBUSREQ_M1) begin
                gnt_next = MST_M1;
            end else if (HBUSREQ_M2) begin
                gnt_next = MST_M2;
            end else begin
                gnt_next = MST_DEF;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            gnt         <= MST_DEF;
            HMASTER     <= MST_DEF;
            HMASTLOCK   <= 1'b0;
            dmaster     <= MST_DEF;
            cnt         <= 5'd0;
            last_served <= MST_M2;
        end else if (HREADY) begin
            gnt       <= gnt_next;
            HMASTER   <= gnt;
            HMASTLOCK <= gnt_lock;
            dmaster   <= HMASTER;
            cnt       <= cnt_next;
            if (HMASTER != MST_DEF && HTRANS == TRANS_NONSEQ) begin
                last_served <= HMASTER;
            end
        end
    end

    assign HGRANT_M1 = (gnt == MST_M1);
    assign HGRANT_M2 = (gnt == MST_M2);

endmodule

// File: doc/ahb_mux_m2s.md
# ahb_mux_m2s

Master-to-slave side of the AHB-Lite-style interconnect: arbitrates two bus masters (M1, M2) plus an internal default master and drives the shared address/control and write-data buses toward the decoder and slaves. It is the counterpart of the slave-to-master response mux and consumes that mux's combined `HREADY`. Address-phase signals are steered by the current bus owner and write data by the data-phase owner, so pipelined ownership handover is correct.

## Interface
- `ADDR_BITS`, 32, address width
- `DATA_BITS`, 32, data width
- `HCLK  in  1  bus clock, all state on rising edge`
- `HRESET  in  1  asynchronous, active-high reset`
- `HREADY  in  1  combined bus ready from the slave-to-master mux`
- `HBUSREQ_M1, HBUSREQ_M2  in  1  bus request`
- `HLOCK_M1, HLOCK_M2  in  1  locked-transfer request`
- `HADDR_Mx  in  ADDR_BITS`; `HTRANS_Mx  in  2`; `HWRITE_Mx  in  1`; `HSIZE_Mx  in  3`; `HBURST_Mx  in  3`; `HWDATA_Mx  in  DATA_BITS  per-master bus signals (x = 1, 2)`
- `HGRANT_M1, HGRANT_M2  out  1  registered grant`
- `HMASTER  out  2  address-phase owner: 0 default, 1 M1, 2 M2`
- `HMASTLOCK  out  1  current address phase is locked`
- `HADDR  out  ADDR_BITS`; `HTRANS  out  2`; `HWRITE  out  1`; `HSIZE  out  3`; `HBURST  out  3  muxed address/control`
- `HWDATA  out  DATA_BITS  muxed write data`

## Operation
- Grant register `gnt` (0/1/2) drives HGRANT_M1 = (gnt==1), HGRANT_M2 = (gnt==2). gnt is updated only on edges with HREADY=1 and not held.
- Arbitration when not held: both request -> the master != `last_served`; one requests -> that one; none -> default (0).
- `last_served` <= HMASTER on each edge with HREADY=1, HMASTER!=0 and HTRANS==NONSEQ.
- Hold (gnt frozen): HMASTLOCK-side request, i.e. HLOCK of the granted master =1; or `cnt_next` >= 2.
- Beat counter `cnt` (5 bits) tracks the owner's fixed-length burst. On HREADY edge: HTRANS==NONSEQ -> cnt <= len-1, where len = 4 (WRAP4/INCR4), 8 (WRAP8/INCR8), 16 (WRAP16/INCR16), 1 (SINGLE/INCR); HTRANS==SEQ and cnt!=0 -> cnt <= cnt-1; IDLE/BUSY -> unchanged. `cnt_next` is the value being loaded this edge.
- INCR (undefined length) is never held; the arbiter may move the grant after any beat.
- HMASTER <= gnt and HMASTLOCK <= HLOCK of gnt on each HREADY edge.
- Data-phase owner `dmaster` <= HMASTER on each HREADY edge.
- Address mux selected by HMASTER; HWDATA selected by dmaster.
- Default master (select 0) drives HADDR=0, HTRANS=IDLE (2'b00), HWRITE=0, HSIZE=3'b010, HBURST=SINGLE, HWDATA=0.
- HRESP is not used; SPLIT/RETRY are unsupported.

## Timing
- Reset (async, HRESET=1): gnt=0, HGRANT_M1=HGRANT_M2=0, HMASTER=0, dmaster=0, HMASTLOCK=0, cnt=0, last_served=2, so M1 wins the first tie. Outputs therefore show the default master: HTRANS=IDLE, HADDR=0, HWDATA=0.
- Request to grant: 1 cycle. HBUSREQ is sampled at edge e with HREADY=1, and HGRANT is high after e.
- Grant to ownership: HMASTER switches at the next HREADY edge after HGRANT rises.
- Write data follows ownership one HREADY edge later.
- HREADY=0: gnt, HMASTER, dmaster, cnt, last_served and HMASTLOCK are all frozen.
- Fixed-length bursts:
  - INCR4 NONSEQ at e0 loads cnt=3. SEQ at e1 gives cnt=2, and at e2 gives cnt=1.
  - The grant may change at e2 (cnt_next=1), and HMASTER switches at e3, the edge where the last beat is accepted. There is no lost cycle.
- Wait states inside a burst stretch the hold. BUSY beats do not decrement cnt.
- Simultaneous requests on an unheld HREADY edge resolve via last_served only, with no combinational grant.
- A request withdrawn while granted but before NONSEQ: the grant moves at the next unheld HREADY edge.
- Reset mid-burst: immediate return to reset values. A master must restart with NONSEQ.

## Test plan
- Reset, then M1 requests, then one cycle later M2 requests.
  - Required: HGRANT_M1=1 after the first HREADY edge; HMASTER=1 one edge later.
  - M1 SINGLE NONSEQ to 0x100 accepted -> grant passes to M2; HMASTER=2 two edges after M1's NONSEQ.
- Both request from reset -> M1 granted first. After M1's NONSEQ, grant goes to M2; after M2's NONSEQ, back to M1 (alternation).
- M1 INCR4 write at 0x200 with M2 requesting and HREADY=1 throughout.
  - Required: HADDR 0x200/204/208/20C from M1.
  - HGRANT_M2 rises after the third beat's edge; HMASTER=2 coincides with acceptance of 0x20C.
  - HWDATA shows M1's data for all 4 beats.
- Same INCR4 with HREADY=0 for 3 cycles on beat 2 -> HMASTER, gnt and cnt frozen; burst completes unbroken; HWDATA held on M1 data.
- M1 HLOCK=1 across two SINGLE transfers while M2 requests -> grant stays M1 with HMASTLOCK=1; grant moves one edge after HLOCK drops.
- Assert HRESET mid-INCR8 -> all outputs return to reset values the same cycle; after release, HTRANS=IDLE and HMASTER=0.
